// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmit/receive chain.
// Holds the frame FSM state encoding, the antipodal symbol codes and
// the default word widths of the two coding paths.
package bpsk_pkg;

    // Frame sequencing states shared by serializer and deserializer
    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        GAP
    } state_t;

    // Two-bit signed symbol codes: +1, -1 and "no symbol"
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b11;
    localparam logic [1:0] SYM_IDLE = 2'b00;

    // Modulated word widths for the Hamming and BCH coding paths
    localparam int N_HAMMING = 24;
    localparam int N_BCH     = 15;

    // A data bit of 0 goes out as +1, a data bit of 1 as -1
    function automatic logic [1:0] symOf(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

endpackage

// File: rtl/bpsk_serializer_if.sv
// Load handshake and symbol stream between the BPSK modulator, the
// serializer and the channel model. The master side supplies words and
// the downstream stall; the slave side (the serializer) produces symbols.
interface bpsk_serializer_if
    import bpsk_pkg::*;
#(
    parameter int N = N_HAMMING
);

    logic [N-1:0] DataIn;
    logic         LoadValid;
    logic         LoadReady;
    logic         Hold;
    logic [1:0]   SymOut;
    logic         SymValid;
    logic         FrameStart;
    logic         FrameEnd;
    logic [7:0]   FrameCount;

    modport master (
        output DataIn,
        output LoadValid,
        output Hold,
        input  LoadReady,
        input  SymOut,
        input  SymValid,
        input  FrameStart,
        input  FrameEnd,
        input  FrameCount
    );

    modport slave (
        input  DataIn,
        input  LoadValid,
        input  Hold,
        output LoadReady,
        output SymOut,
        output SymValid,
        output FrameStart,
        output FrameEnd,
        output FrameCount
    );

endinterface

// File: rtl/bpsk_piso.sv
// N-bit parallel-in, serial-out shift register, MSB first.
// Besides the current MSB it exposes the bit that becomes the MSB after
// the next shift, so a registered consumer can stage the following bit.
module bpsk_piso #(
    parameter int N = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] data_i,
    output logic         msb_o,
    output logic         next_o
);

    logic [N-1:0] shreg_q;

    // Load has priority over shift; both leave the register alone when idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb_o = shreg_q[N-1];

    generate
        if (N > 1) begin : g_next
            assign next_o = shreg_q[N-2];
        end else begin : g_single
            assign next_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bpsk_serializer.sv
// Frame serializer placed after the BPSK modulator. Each accepted word is
// sent as a preamble followed by the word MSB first, as registered
// antipodal symbols, then an idle gap before the next word is accepted.
// A downstream Hold freezes the whole frame in place.
module bpsk_serializer
    import bpsk_pkg::*;
#(
    parameter int          N            = N_HAMMING,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [31:0] PREAMBLE     = 32'h000000A5,
    parameter int          GAP_LEN      = 4
) (
    input logic              CLK,
    input logic              RST,
    bpsk_serializer_if.slave bus
);

    localparam int SYM_W = $clog2(PREAMBLE_LEN + N + 1);
    localparam int GAP_W = $clog2(GAP_LEN + 1);

    localparam logic [SYM_W-1:0] PRE_LAST  = SYM_W'(PREAMBLE_LEN - 1);
    localparam logic [SYM_W-1:0] DATA_LAST = SYM_W'(PREAMBLE_LEN + N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LEN - 1);

    // Preamble left-justified so its first symbol always sits in bit 31
    localparam logic [31:0] PRE_ALIGNED = PREAMBLE << (32 - PREAMBLE_LEN);

    state_t           state_q;
    logic [SYM_W-1:0] symCnt_q;
    logic [GAP_W-1:0] gapCnt_q;
    logic [31:0]      preShift_q;
    logic [1:0]       symOut_q;
    logic             loadReady_q;
    logic [7:0]       frameCnt_q;

    logic loadEn;
    logic shiftEn;
    logic dataMsb;
    logic dataNext;
    logic active;

    assign loadEn  = loadReady_q && bus.LoadValid;
    assign shiftEn = (state_q == DATA) && !bus.Hold;
    assign active  = (state_q == PRE) || (state_q == DATA);

    bpsk_piso #(
        .N (N)
    ) u_piso (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (loadEn),
        .shift_i (shiftEn),
        .data_i  (bus.DataIn),
        .msb_o   (dataMsb),
        .next_o  (dataNext)
    );

    // Frame sequencer: each state stages the symbol for the following cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            symCnt_q    <= '0;
            gapCnt_q    <= '0;
            preShift_q  <= '0;
            symOut_q    <= SYM_IDLE;
            loadReady_q <= 1'b1;
            frameCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.LoadValid) begin
                        state_q     <= PRE;
                        loadReady_q <= 1'b0;
                        symCnt_q    <= '0;
                        preShift_q  <= PRE_ALIGNED << 1;
                        symOut_q    <= symOf(PRE_ALIGNED[31]);
                    end
                end
                PRE: begin
                    if (!bus.Hold) begin
                        symCnt_q   <= symCnt_q + 1'b1;
                        preShift_q <= preShift_q << 1;
                        if (symCnt_q == PRE_LAST) begin
                            state_q  <= DATA;
                            symOut_q <= symOf(dataMsb);
                        end else begin
                            symOut_q <= symOf(preShift_q[31]);
                        end
                    end
                end
                DATA: begin
                    if (!bus.Hold) begin
                        symCnt_q <= symCnt_q + 1'b1;
                        if (symCnt_q == DATA_LAST) begin
                            state_q    <= GAP;
                            gapCnt_q   <= '0;
                            symOut_q   <= SYM_IDLE;
                            frameCnt_q <= frameCnt_q + 8'd1;
                        end else begin
                            symOut_q <= symOf(dataNext);
                        end
                    end
                end
                GAP: begin
                    if (!bus.Hold) begin
                        if (gapCnt_q == GAP_LAST) begin
                            state_q     <= IDLE;
                            loadReady_q <= 1'b1;
                        end else begin
                            gapCnt_q <= gapCnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.LoadReady  = loadReady_q;
    assign bus.SymOut     = symOut_q;
    assign bus.SymValid   = active && !bus.Hold;
    assign bus.FrameStart = (state_q == PRE) && (symCnt_q == '0) && !bus.Hold;
    assign bus.FrameEnd   = (state_q == DATA) && (symCnt_q == DATA_LAST) && !bus.Hold;
    assign bus.FrameCount = frameCnt_q;

endmodule

// File: tb/tb_bpsk_serializer.sv
// Bench for bpsk_serializer: one instance with default parameters and one
// with the BCH width and the shortest preamble and gap. Expected symbol
// streams are built from the preamble pattern and data word bit by bit.
module tb_bpsk_serializer;

    localparam int          N0   = 24;
    localparam int          PL0  = 8;
    localparam int          GAP0 = 4;
    localparam int          N1   = 15;
    localparam int          PL1  = 1;
    localparam int          GAP1 = 1;
    localparam logic [31:0] PRE  = 32'h000000A5;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   errors = 0;
    int   checks = 0;
    int   cycleNo = 0;

    logic [7:0] expCount0 = 8'd0;
    logic [7:0] expCount1 = 8'd0;

    bpsk_serializer_if #(.N(N0)) bus0 ();
    bpsk_serializer_if #(.N(N1)) bus1 ();

    bpsk_serializer #(
        .N            (N0),
        .PREAMBLE_LEN (PL0),
        .PREAMBLE     (PRE),
        .GAP_LEN      (GAP0)
    ) dut (
        .CLK (clk),
        .RST (rst0),
        .bus (bus0)
    );

    bpsk_serializer #(
        .N            (N1),
        .PREAMBLE_LEN (PL1),
        .PREAMBLE     (PRE),
        .GAP_LEN      (GAP1)
    ) dutBch (
        .CLK (clk),
        .RST (rst1),
        .bus (bus1)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    // Edge counter used to measure frame-to-frame spacing
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Safety net in case a handshake never completes
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] dataIn, input logic loadValid,
                                 input logic hold);
        bus0.DataIn    = dataIn;
        bus0.LoadValid = loadValid;
        bus0.Hold      = hold;
    endtask

    task automatic applyStimulusBch(input logic [14:0] dataIn, input logic loadValid);
        bus1.DataIn    = dataIn;
        bus1.LoadValid = loadValid;
        bus1.Hold      = 1'b0;
    endtask

    function automatic logic [1:0] expSymOf(input bit b);
        return b ? 2'b11 : 2'b01;
    endfunction

    // Sends one word to the default instance and checks the whole frame.
    // Entered and left just after a rising edge.
    task automatic runFrame0(input logic [23:0] word, input logic [23:0] otherWord,
                             input bit keepValid, input int pulseAt, input int holdAt,
                             input int holdLen, input int abortAt, input bit expectReady,
                             output int startCyc);
        bit expBits[$];
        int idx;
        int held;
        int total;
        int last;
        int waitCnt;
        bit hold;
        expBits = {};
        for (int i = PL0 - 1; i >= 0; i--) expBits.push_back(PRE[i]);
        for (int i = N0 - 1; i >= 0; i--) expBits.push_back(word[i]);
        last = expBits.size() - 1;

        applyStimulus(word, 1'b1, 1'b0);
        @(negedge clk);
        if (expectReady) checkOutput("loadReadyBeforeLoad", 32'(bus0.LoadReady), 32'd1);
        waitCnt = 0;
        while (bus0.LoadReady !== 1'b1 && waitCnt < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("handshakeTimeout", 32'(waitCnt < 200), 32'd1);
        @(posedge clk); #1;
        startCyc = cycleNo;

        idx = 0;
        held = 0;
        total = 0;
        while (idx <= last && total < 200) begin
            hold = (idx == holdAt) && (held < holdLen);
            applyStimulus(otherWord, keepValid || (idx == pulseAt), hold);
            @(negedge clk);
            checkOutput("symOut", 32'(bus0.SymOut), 32'(expSymOf(expBits[idx])));
            checkOutput("symValid", 32'(bus0.SymValid), 32'(!hold));
            checkOutput("frameStart", 32'(bus0.FrameStart), 32'(!hold && idx == 0));
            checkOutput("frameEnd", 32'(bus0.FrameEnd), 32'(!hold && idx == last));
            checkOutput("loadReadyBusy", 32'(bus0.LoadReady), 32'd0);
            if (idx == last) checkOutput("countBeforeEnd", 32'(bus0.FrameCount), 32'(expCount0));
            if (idx == abortAt) begin
                #1 rst0 = 1'b1;
                #1;
                checkOutput("rstLoadReady", 32'(bus0.LoadReady), 32'd1);
                checkOutput("rstSymValid", 32'(bus0.SymValid), 32'd0);
                checkOutput("rstSymOut", 32'(bus0.SymOut), 32'd0);
                checkOutput("rstFrameStart", 32'(bus0.FrameStart), 32'd0);
                checkOutput("rstFrameEnd", 32'(bus0.FrameEnd), 32'd0);
                checkOutput("rstFrameCount", 32'(bus0.FrameCount), 32'd0);
                @(posedge clk); #1;
                rst0 = 1'b0;
                applyStimulus(otherWord, 1'b0, 1'b0);
                expCount0 = 8'd0;
                @(negedge clk);
                checkOutput("postRstReady", 32'(bus0.LoadReady), 32'd1);
                checkOutput("postRstValid", 32'(bus0.SymValid), 32'd0);
                checkOutput("postRstCount", 32'(bus0.FrameCount), 32'd0);
                @(posedge clk); #1;
                return;
            end
            if (hold) held++;
            else idx++;
            total++;
            @(posedge clk); #1;
        end
        checkOutput("frameCycles", 32'(total),
                    32'(last + 1 + ((holdAt >= 0 && holdAt <= last) ? holdLen : 0)));

        applyStimulus(otherWord, keepValid, 1'b0);
        expCount0 = expCount0 + 8'd1;
        for (int g = 0; g < GAP0; g++) begin
            @(negedge clk);
            checkOutput("gapValid", 32'(bus0.SymValid), 32'd0);
            checkOutput("gapSymOut", 32'(bus0.SymOut), 32'd0);
            checkOutput("gapReady", 32'(bus0.LoadReady), 32'd0);
            checkOutput("gapCount", 32'(bus0.FrameCount), 32'(expCount0));
            @(posedge clk); #1;
        end
    endtask

    // Sends one word to the BCH instance with LoadValid left high throughout
    task automatic runFrame1(input logic [14:0] word, input bit expectReady,
                             output int startCyc);
        bit expBits[$];
        int waitCnt;
        int last;
        expBits = {};
        for (int i = PL1 - 1; i >= 0; i--) expBits.push_back(PRE[i]);
        for (int i = N1 - 1; i >= 0; i--) expBits.push_back(word[i]);
        last = expBits.size() - 1;

        applyStimulusBch(word, 1'b1);
        @(negedge clk);
        if (expectReady) checkOutput("bchReadyBackToBack", 32'(bus1.LoadReady), 32'd1);
        waitCnt = 0;
        while (bus1.LoadReady !== 1'b1 && waitCnt < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("bchHandshakeTimeout", 32'(waitCnt < 200), 32'd1);
        @(posedge clk); #1;
        startCyc = cycleNo;
        applyStimulusBch(15'($urandom), 1'b1);

        for (int idx = 0; idx <= last; idx++) begin
            @(negedge clk);
            checkOutput("bchSymOut", 32'(bus1.SymOut), 32'(expSymOf(expBits[idx])));
            checkOutput("bchSymValid", 32'(bus1.SymValid), 32'd1);
            checkOutput("bchFrameStart", 32'(bus1.FrameStart), 32'(idx == 0));
            checkOutput("bchFrameEnd", 32'(bus1.FrameEnd), 32'(idx == last));
            @(posedge clk); #1;
        end

        expCount1 = expCount1 + 8'd1;
        for (int g = 0; g < GAP1; g++) begin
            @(negedge clk);
            checkOutput("bchGapValid", 32'(bus1.SymValid), 32'd0);
            checkOutput("bchGapCount", 32'(bus1.FrameCount), 32'(expCount1));
            @(posedge clk); #1;
        end
    endtask

    // Directed and randomized frame sequence, then summary
    initial begin
        int s1;
        int s2;
        int prev;
        logic [23:0] w;

        rst0 = 1'b1;
        rst1 = 1'b1;
        applyStimulus(24'h0, 1'b0, 1'b0);
        applyStimulusBch(15'h0, 1'b0);
        #12;
        checkOutput("resetLoadReady", 32'(bus0.LoadReady), 32'd1);
        checkOutput("resetSymOut", 32'(bus0.SymOut), 32'd0);
        checkOutput("resetSymValid", 32'(bus0.SymValid), 32'd0);
        checkOutput("resetFrameStart", 32'(bus0.FrameStart), 32'd0);
        checkOutput("resetFrameEnd", 32'(bus0.FrameEnd), 32'd0);
        checkOutput("resetFrameCount", 32'(bus0.FrameCount), 32'd0);
        checkOutput("resetBchReady", 32'(bus1.LoadReady), 32'd1);
        checkOutput("resetBchCount", 32'(bus1.FrameCount), 32'd0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        $display("[TB] reset during preamble symbol 5");
        runFrame0(24'($urandom), 24'($urandom), 1'b0, -1, -1, 0, 4, 1'b1, s1);
        checkOutput("abortedCount", 32'(bus0.FrameCount), 32'd0);

        $display("[TB] basic frame 24'h800001");
        runFrame0(24'h800001, 24'h0, 1'b0, -1, -1, 0, -1, 1'b1, s1);
        checkOutput("basicCount", 32'(bus0.FrameCount), 32'd1);

        $display("[TB] back-to-back frames");
        runFrame0(24'hFFFFFF, 24'h000000, 1'b1, -1, -1, 0, -1, 1'b1, s1);
        runFrame0(24'h000000, 24'($urandom), 1'b0, -1, -1, 0, -1, 1'b1, s2);
        checkOutput("backToBackPeriod", 32'(s2 - s1), 32'(PL0 + N0 + GAP0 + 1));
        checkOutput("backToBackCount", 32'(bus0.FrameCount), 32'd3);

        $display("[TB] hold for 3 cycles at data bit 10");
        runFrame0(24'($urandom), 24'($urandom), 1'b0, -1, PL0 + (N0 - 1 - 10), 3, -1, 1'b1, s1);

        $display("[TB] load pulse during data is ignored");
        w = 24'($urandom);
        runFrame0(w, ~w, 1'b0, PL0 + 5, -1, 0, -1, 1'b1, s1);
        applyStimulus(~w, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idleNoResend", 32'(bus0.SymValid), 32'd0);
            checkOutput("idleReady", 32'(bus0.LoadReady), 32'd1);
            checkOutput("idleCount", 32'(bus0.FrameCount), 32'(expCount0));
            @(posedge clk); #1;
        end

        $display("[TB] random frames with random holds");
        for (int r = 0; r < 6; r++) begin
            runFrame0(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), -1,
                      int'($urandom_range(0, PL0 + N0 - 1)), int'($urandom_range(1, 3)),
                      -1, 1'b0, s1);
        end

        $display("[TB] BCH width, 256 back-to-back frames");
        prev = 0;
        for (int f = 0; f < 256; f++) begin
            runFrame1(15'($urandom), f > 0, s1);
            if (f > 0) checkOutput("bchPeriod", 32'(s1 - prev), 32'(PL1 + N1 + GAP1 + 1));
            prev = s1;
        end
        checkOutput("bchWrap", 32'(bus1.FrameCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpsk_serializer.md
# bpsk_serializer

- Transmit-side stage directly downstream of the BPSK modulator.
- Accepts one N-bit modulated word per frame through a valid/ready handshake.
- Emits the frame serially, MSB first, as signed antipodal symbols, preceded by a fixed preamble and followed by an idle gap.
- Feeds the channel/noise model and the receiver chain.

## Interface
- N, 24: data word width (15 for the BCH path).
- PREAMBLE_LEN, 8: preamble symbols per frame, 1..32.
- PREAMBLE, 32'h000000A5: preamble pattern; low PREAMBLE_LEN bits used, sent MSB first.
- GAP_LEN, 4: idle cycles after each frame, minimum 1.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DataIn  in  N  modulated word from BPSK stage.
- LoadValid  in  1  DataIn valid.
- LoadReady  out  1  serializer can accept a word.
- Hold  in  1  downstream stall.
- SymOut  out  2  signed symbol: 2'b01 = +1 (bit 0), 2'b11 = −1 (bit 1), 2'b00 = idle.
- SymValid  out  1  SymOut is a live symbol this cycle.
- FrameStart  out  1  first preamble symbol, qualified by SymValid.
- FrameEnd  out  1  last data symbol, qualified by SymValid.
- FrameCount  out  8  completed frames, wraps 255→0.

## Operation
States:
- IDLE: LoadReady=1, SymOut=0, SymValid=0. Hold is ignored. LoadValid&LoadReady at an edge captures DataIn into a shift register and moves to PRE.
- PRE: emits PREAMBLE bits [PREAMBLE_LEN−1:0], MSB first, one per unstalled edge. After the last preamble symbol the state moves to DATA.
- DATA: emits DataIn[N−1] down to DataIn[0]. The edge retiring bit 0 moves to GAP and increments FrameCount.
- GAP: SymOut=0, SymValid=0 for GAP_LEN unstalled edges, then IDLE.

Symbol and handshake rules:
- Bit mapping: 0 → 2'b01, 1 → 2'b11. SymOut is registered.
- Symbol consumption: a symbol is consumed on an edge only when SymValid=1.
- SymValid is active (PRE or DATA) & ~Hold. FrameStart and FrameEnd are gated the same way.
- Hold=1 in PRE, DATA or GAP freezes state, counters, shift register and SymOut. The held symbol reappears valid once Hold drops.
- LoadReady=0 outside IDLE. LoadValid is ignored there and no word is dropped or queued.
- Symbol counter width is clog2(PREAMBLE_LEN+N+1). GAP counter width is clog2(GAP_LEN+1).

## Timing
- Reset values: LoadReady=1, SymOut=0, SymValid=0, FrameStart=0, FrameEnd=0, FrameCount=0, state IDLE.
- Reset mid-frame: the frame is abandoned immediately and outputs take their reset values asynchronously. FrameCount does not increment for the abandoned frame.
- Latency: for a handshake at edge k, the first preamble symbol is on SymOut after edge k.
- With no Hold, symbols occupy PREAMBLE_LEN+N consecutive cycles, then GAP_LEN idle cycles.
- LoadReady returns after edge k+PREAMBLE_LEN+N+GAP_LEN.
- Minimum frame period is PREAMBLE_LEN+N+GAP_LEN+1 cycles.
- FrameCount updates on the edge retiring the FrameEnd symbol.
- Hold asserted in the same cycle as FrameEnd delays both the count and the GAP entry.
- LoadValid asserted in the cycle LoadReady rises is accepted at that edge, giving back-to-back frames.

## Structure
- Shared package bpsk_pkg holds:
  - state enum {IDLE, PRE, DATA, GAP};
  - SYM_POS=2'b01, SYM_NEG=2'b11, SYM_IDLE=2'b00;
  - default N values for the Hamming (24) and BCH (15) paths.
- Sub-module bpsk_piso: N-bit parallel-load, MSB-first shift register with load and shift-enable inputs. It is reused by the receiver deserializer's loopback checker.
- The FSM, counters and symbol mapping live in the top level.

## Test plan
- Basic frame: defaults, DataIn=24'h800001, one handshake. Required response:
  - preamble 8'hA5 gives −1,+1,−1,+1,+1,−1,+1,−1;
  - then −1, 22×(+1), −1;
  - FrameStart on symbol 1, FrameEnd on symbol 32;
  - 4 idle cycles, FrameCount=1.
- Back-to-back: LoadValid held high with 24'hFFFFFF then 24'h000000. Required response:
  - the second frame starts exactly 37 cycles after the first;
  - data symbols are all −1 then all +1;
  - FrameCount=2.
- Hold: assert Hold for 3 cycles at data bit 10. Required response:
  - SymValid=0 for those 3 cycles and SymOut frozen at the bit-10 symbol;
  - the stream resumes with no symbol lost or duplicated;
  - the frame ends 3 cycles late.
- Reset mid-frame: RST pulse during preamble symbol 5. Required response:
  - outputs go to reset values before the next edge;
  - FrameCount stays 0;
  - LoadReady=1 after RST drops.
- Wrap and BCH width: N=15, PREAMBLE_LEN=1, GAP_LEN=1, 256 frames. Required response:
  - FrameCount wraps to 0;
  - each frame is 16 symbols plus 1 gap cycle.
- Ignored load: LoadValid pulsed during DATA with a different word. Required response:
  - the current frame is unaltered;
  - the pulsed word is not transmitted.
